// File: rtl/uart_debug_loader_pkg.sv
// rtl/uart_debug_loader_pkg.sv - shared state encoding, byte order and defaults for the UART debug loader
package uart_debug_loader_pkg;

  typedef enum logic [2:0] {
    ST_RECV      = 3'd0,
    ST_STEP_LO   = 3'd1,
    ST_STEP_HI   = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_TX_ISSUE  = 3'd4,
    ST_TX_WAITHI = 3'd5,
    ST_TX_WAITLO = 3'd6
  } state_t;

  localparam logic        LITTLE_ENDIAN      = 1'b1;
  localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd1200000;
  localparam logic [3:0]  DEF_SETTLE_CYCLES  = 4'd2;

  function automatic logic [1:0] byte_lane(input logic [1:0] idx);
    return LITTLE_ENDIAN ? idx : 2'd3 - idx;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte idle counter that saturates at LIMIT-1 and flags expiry
module byte_timeout
  import uart_debug_loader_pkg::*;
#(
  parameter logic [23:0] LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [23:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 24'd1;
    end
  end

  assign o_expired = (r_count == LIMIT - 24'd1);

endmodule

// File: rtl/uart_debug_loader.sv
// rtl/uart_debug_loader.sv - assembles 4 RX bytes into testWord, pulses stepClock, returns result over TX
module uart_debug_loader
  import uart_debug_loader_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [3:0]  SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int          RESULT_BYTES   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RXbuffer,
  input  logic        RXready,
  input  logic        TXbusy,
  input  logic [15:0] result,
  output logic [7:0]  TXbuffer,
  output logic        TXstart,
  output logic [31:0] testWord,
  output logic        stepClock,
  output logic        busy,
  output logic        overrun
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_shadow;
  logic [31:0] w_shadow_next;
  logic [3:0]  r_settle;
  logic [15:0] r_capture;
  logic        r_tx_idx;
  logic        w_rx_accept;
  logic        w_commit;
  logic        w_to_en;
  logic        w_to_clr;
  logic        w_expired;
  logic        w_settled;
  logic        w_tx_fire;
  logic        w_tx_last;

  assign w_rx_accept = (r_state == ST_RECV) && RXready;
  assign w_commit    = w_rx_accept && (r_cnt == 2'd3);
  assign w_to_en     = (r_state == ST_RECV) && (r_cnt != 2'd0) && !RXready;
  assign w_to_clr    = w_rx_accept || (w_to_en && w_expired);
  assign w_settled   = (r_settle == SETTLE_CYCLES - 4'd1);
  assign w_tx_fire   = (r_state == ST_TX_ISSUE) && !TXbusy;
  assign w_tx_last   = (int'(r_tx_idx) == RESULT_BYTES - 1);

  byte_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (w_to_clr),
    .i_en      (w_to_en),
    .o_expired (w_expired)
  );

  // Shadow with the incoming byte merged, so the commit edge sees the full word.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[{byte_lane(r_cnt), 3'b000} +: 8] = RXbuffer;
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_RECV;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RECV:      if (w_commit) w_next = ST_STEP_LO;
      ST_STEP_LO:   w_next = ST_STEP_HI;
      ST_STEP_HI:   w_next = ST_SETTLE;
      ST_SETTLE:    if (w_settled) w_next = ST_TX_ISSUE;
      ST_TX_ISSUE:  if (!TXbusy) w_next = ST_TX_WAITHI;
      ST_TX_WAITHI: if (TXbusy) w_next = ST_TX_WAITLO;
      ST_TX_WAITLO: if (!TXbusy) w_next = w_tx_last ? ST_RECV : ST_TX_ISSUE;
      default:      w_next = ST_RECV;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      TXbuffer  <= '0;
      TXstart   <= 1'b0;
      testWord  <= '0;
      stepClock <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_settle  <= '0;
      r_capture <= '0;
      r_tx_idx  <= 1'b0;
    end else begin
      TXstart <= 1'b0;
      if (RXready && busy) overrun <= 1'b1;
      if (w_rx_accept) begin
        r_shadow <= w_shadow_next;
        r_cnt    <= w_commit ? 2'd0 : r_cnt + 2'd1;
      end else if (w_to_en && w_expired) begin
        r_cnt <= 2'd0;
      end
      if (w_commit) begin
        testWord <= w_shadow_next;
        busy     <= 1'b1;
      end
      if (r_state == ST_STEP_LO) stepClock <= 1'b0;
      if (r_state == ST_STEP_HI) begin
        stepClock <= 1'b1;
        r_settle  <= '0;
      end
      if (r_state == ST_SETTLE) begin
        if (w_settled) begin
          r_capture <= result;
          r_tx_idx  <= 1'b0;
        end else begin
          r_settle <= r_settle + 4'd1;
        end
      end
      if (w_tx_fire) begin
        TXbuffer <= r_tx_idx ? r_capture[15:8] : r_capture[7:0];
        TXstart  <= 1'b1;
      end
      if ((r_state == ST_TX_WAITLO) && !TXbusy) begin
        if (w_tx_last) busy <= 1'b0;
        else           r_tx_idx <= r_tx_idx + 1'b1;
      end
    end
  end

endmodule
